// File: rtl/xor_cksum_pkg.sv
// rtl/xor_cksum_pkg.sv - shared types, mode constants and rotate helper for the XOR checksum unit
package xor_cksum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Rotate the low w bits of v left by one; bits above w are returned as zero.
    // Written against a 64-bit carrier so any word width up to 64 can share it.
    function automatic logic [63:0] rotl1(input logic [63:0] v, input int unsigned w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return ((v << 1) | ((v & mask) >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/xor_word_n.sv
// rtl/xor_word_n.sv - WIDTH-bit bitwise XOR of two words
module xor_word_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_checksum_unit.sv
// rtl/xor_checksum_unit.sv - streaming XOR checksum generator/checker; XOR_CKSUM_ROTATE_EN selects rotate-then-XOR accumulation
module xor_checksum_unit
    import xor_cksum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    input  logic                             mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_sum,
    output logic                             out_parity,
    output logic                             out_match,
    output logic                             out_err_len,
    output logic [$clog2(MAX_WORDS+1)-1:0]   out_count
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q;
    logic [CW-1:0]     count_q;
    logic              mode_q;

    logic              accept;
    logic              take;
    logic              first;
    logic [WIDTH-1:0]  acc_src;
    logic [WIDTH-1:0]  acc_xor;
    logic [WIDTH-1:0]  acc_d;
    logic [CW-1:0]     count_d;
    logic              mode_eff;
    logic              hit_max;
    logic              finish;
    logic              err_d;

    // Handshake status depends on the registered state only, so no ready/valid loop forms.
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    assign first     = (state_q == IDLE);

`ifdef XOR_CKSUM_ROTATE_EN
    assign acc_src = WIDTH'(rotl1(64'(acc_q), WIDTH));
`else
    assign acc_src = acc_q;
`endif

    xor_word_n #(.WIDTH(WIDTH)) u_xor (
        .a (acc_src),
        .b (in_data),
        .y (acc_xor)
    );

    // The first word of a frame loads the accumulator directly; later words fold in.
    assign acc_d    = first ? in_data : acc_xor;
    assign count_d  = first ? CW'(1) : count_q + CW'(1);
    assign mode_eff = first ? mode : mode_q;
    assign hit_max  = (count_d == MAX_CNT);
    assign finish   = accept & (in_last | hit_max);
    assign err_d    = ~in_last & hit_max;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: complete on in_last or when the word budget is exhausted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d = finish ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (take) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator datapath; result registers only change when a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            count_q     <= '0;
            mode_q      <= MODE_GEN;
            out_sum     <= '0;
            out_parity  <= 1'b0;
            out_match   <= 1'b0;
            out_err_len <= 1'b0;
            out_count   <= '0;
        end else if (accept) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            if (first) begin
                mode_q <= mode;
            end
            if (finish) begin
                out_sum     <= acc_d;
                out_parity  <= ^acc_d;
                out_match   <= (mode_eff == MODE_CHK) && (acc_d == '0);
                out_err_len <= err_d;
                out_count   <= count_d;
            end
        end
    end

endmodule

// File: doc/xor_checksum_unit.md
Name: xor_checksum_unit

Overview:
- Streaming XOR checksum generator/checker; parametrised successor of the team's single-bit XOR gate.
- Accepts WIDTH-bit words over a valid/ready handshake and XOR-accumulates a frame delimited by in_last.
- Presents the checksum, its reduction parity and a check verdict on an output handshake.
- Sits between a word source (UART/switch capture) and display/compare logic.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- MAX_WORDS, 16, maximum words per frame (>=2); count width = clog2(MAX_WORDS+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  unit can accept a word.
- in_data  in  WIDTH  input word.
- in_last  in  1  final word of frame; qualified by in_valid.
- mode  in  1  0 = generate, 1 = check; sampled only on a frame's first accepted word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  accumulated XOR of the frame.
- out_parity  out  1  reduction XOR of out_sum.
- out_match  out  1  check mode: out_sum == 0; generate mode: 0.
- out_err_len  out  1  frame truncated at MAX_WORDS words.
- out_count  out  clog2(MAX_WORDS+1)  words accepted in the frame.

Behaviour:
- Reset (async assert, sync release): state IDLE; acc, count, mode_q and err cleared. in_ready=1; out_valid, out_sum, out_parity, out_match, out_err_len and out_count = 0.
- Accept = in_valid & in_ready. Result = out_valid & out_ready.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On accept: acc<=in_data, count<=1, mode_q<=mode.
  - Go to DONE if in_last, else to ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: acc<=acc^in_data, count<=count+1.
  - Go to DONE if in_last, or if count+1==MAX_WORDS. The MAX_WORDS case with in_last=0 sets err.
  - No accept: hold state and values.
- DONE:
  - in_ready=0; out_valid=1. All outputs stable until the result is taken.
  - On result: go to IDLE. Outputs stay registered until the next frame completes; out_valid drops.
- Latency: result visible the cycle after the last word is accepted. Throughput is one frame per (N+1) cycles minimum.
- Single-word frame (first word with in_last): out_sum = that word, out_count = 1.
- in_last=1 on word MAX_WORDS: normal completion, err=0.
- in_ready is combinational from state only; there is no in_ready-to-in_valid loop.
- out_match = mode_q & (acc==0). out_parity = ^acc. Both are registered with the DONE transition.
- mode changes mid-frame are ignored.
- in_data is ignored when in_valid=0. in_last is ignored without in_valid.
- rst_n asserted mid-frame or in DONE: the partial frame is discarded and all outputs return to reset values immediately.

Optional Feature:
- XOR_CKSUM_ROTATE_EN defined:
  - Accumulation is acc<=rotl1(acc)^in_data; the first word loads unrotated.
  - This detects word reordering.
- Not defined: plain XOR as above.
- out_parity and out_match are computed on the resulting acc in both cases.

Decomposition:
- Package xor_cksum_pkg holds:
  - state enum (IDLE, ACCUM, DONE)
  - mode constants MODE_GEN=1'b0, MODE_CHK=1'b1
  - rotl1 function
- Natural sub-module xor_word_n: parametric WIDTH-bit bitwise XOR of two words. It is the generalised gate, instantiated for the accumulator datapath.

Test Plan:
- Reset, then generate frame 8'h12, 8'h34, 8'h0F(last) -> out_sum=8'h29, out_parity=1, out_count=2'd3→3, out_match=0, err=0; out_valid held until out_ready.
- Check frame 8'hA5, 8'h3C, 8'h99(last) -> out_sum=8'h00, out_match=1, out_parity=0.
- MAX_WORDS=16 with 17 words of 8'h01 and no in_last -> DONE after word 16, out_err_len=1, out_count=16, out_sum=8'h00, in_ready=0 on the 17th.
- Single word 8'hFF with last, out_ready held low for 5 cycles -> out_valid stays 1 and in_ready stays 0; released on the 6th cycle; the next frame is accepted the following cycle.
- rst_n pulsed low after 2 words of a 4-word frame -> outputs zero asynchronously; a new frame 8'h55(last) gives out_sum=8'h55.
- XOR_CKSUM_ROTATE_EN defined: 8'h81, 8'h01(last) -> out_sum=8'h02; without the macro -> 8'h80.
